// File: rtl/count_seq_ctrl.sv
// Command sequencer for the seconds counter on the 1 Hz domain: start/pause/clear,
// programmable terminal value, up/down direction, one-shot or auto-reload.
module count_seq_ctrl #(
  parameter int unsigned          WIDTH        = 7,
  parameter logic [WIDTH-1:0]     DEFAULT_TERM = WIDTH'(99)
) (
  input  logic             clk_1Hz,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             clear,
  input  logic [WIDTH-1:0] term,
  input  logic             dir,
  input  logic             reload,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             paused,
  output logic             done,
  output logic             wrap
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_PAUSE,
    ST_DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] term_q;
  logic             dir_q;
  logic             reload_q;

  logic [WIDTH-1:0] start_val;
  logic [WIDTH-1:0] end_val;
  logic [WIDTH-1:0] next_val;

  // Start/end values come from the latched run settings, never the live inputs.
  assign start_val = dir_q ? term_q : '0;
  assign end_val   = dir_q ? '0 : term_q;
  assign next_val  = dir_q ? count - WIDTH'(1) : count + WIDTH'(1);

  // NOTE: every register here is assigned with <= so all next-state values are
  // computed from the pre-edge state; a blocking = would leak updates within the edge.
  always_ff @(posedge clk_1Hz or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      count    <= '0;
      busy     <= 1'b0;
      paused   <= 1'b0;
      done     <= 1'b0;
      wrap     <= 1'b0;
      term_q   <= DEFAULT_TERM;
      dir_q    <= 1'b0;
      reload_q <= 1'b0;
    end else begin
      // Event pulses default low so each lasts exactly one cycle.
      done <= 1'b0;
      wrap <= 1'b0;

      if (clear) begin
        state  <= ST_IDLE;
        count  <= '0;
        busy   <= 1'b0;
        paused <= 1'b0;
      end else begin
        unique case (state)
          ST_IDLE, ST_DONE: begin
            if (start && !stop) begin
              term_q   <= term;
              dir_q    <= dir;
              reload_q <= reload;
              count    <= dir ? term : '0;
              paused   <= 1'b0;
              // A zero-length one-shot run finishes on the start edge itself.
              if (term == '0 && !reload) begin
                state <= ST_DONE;
                busy  <= 1'b0;
                done  <= 1'b1;
              end else begin
                state <= ST_RUN;
                busy  <= 1'b1;
              end
            end
          end

          ST_RUN: begin
            if (stop) begin
              state  <= ST_PAUSE;
              paused <= 1'b1;
            end else if (count == end_val && reload_q) begin
              count <= start_val;
              wrap  <= 1'b1;
            end else begin
              count <= next_val;
              if (next_val == end_val && !reload_q) begin
                state <= ST_DONE;
                busy  <= 1'b0;
                done  <= 1'b1;
              end
            end
          end

          ST_PAUSE: begin
            if (start && !stop) begin
              state  <= ST_RUN;
              paused <= 1'b0;
            end
          end

          default: begin
            state  <= ST_IDLE;
            count  <= '0;
            busy   <= 1'b0;
            paused <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_count_seq_ctrl.sv
// Self-checking bench for count_seq_ctrl: per-scenario tasks feed a scoreboard of
// expected registered outputs, compared one cycle at a time after each rising edge.
module tb_count_seq_ctrl;

  localparam int WIDTH = 7;

  logic             clk_1Hz = 1'b0;
  logic             rst;
  logic             start;
  logic             stop;
  logic             clear;
  logic [WIDTH-1:0] term;
  logic             dir;
  logic             reload;
  logic [WIDTH-1:0] count;
  logic             busy;
  logic             paused;
  logic             done;
  logic             wrap;

  typedef struct packed {
    logic [WIDTH-1:0] count;
    logic             busy;
    logic             paused;
    logic             done;
    logic             wrap;
  } out_t;

  typedef struct {
    string tag;
    out_t  v;
  } exp_t;

  typedef struct {
    string            tag;
    bit               s;
    bit               p;
    bit               c;
    logic [WIDTH-1:0] t;
    bit               d;
    bit               r;
    out_t             v;
  } step_t;

  exp_t  sb[$];
  step_t plan[$];
  int    checks = 0;
  int    errors = 0;

  always #5 clk_1Hz = ~clk_1Hz;

  count_seq_ctrl #(.WIDTH(WIDTH), .DEFAULT_TERM(7'd99)) dut (
    .clk_1Hz (clk_1Hz),
    .rst     (rst),
    .start   (start),
    .stop    (stop),
    .clear   (clear),
    .term    (term),
    .dir     (dir),
    .reload  (reload),
    .count   (count),
    .busy    (busy),
    .paused  (paused),
    .done    (done),
    .wrap    (wrap)
  );

  function automatic out_t mk(int ec, bit eb, bit ep, bit ed, bit ew);
    out_t o;
    o.count  = WIDTH'(ec);
    o.busy   = eb;
    o.paused = ep;
    o.done   = ed;
    o.wrap   = ew;
    return o;
  endfunction

  function automatic out_t observed();
    out_t o;
    o.count  = count;
    o.busy   = busy;
    o.paused = paused;
    o.done   = done;
    o.wrap   = wrap;
    return o;
  endfunction

  function automatic string fmt(out_t v);
    return $sformatf("count=%0d busy=%0b paused=%0b done=%0b wrap=%0b",
                     v.count, v.busy, v.paused, v.done, v.wrap);
  endfunction

  // One planned edge: commands and run settings to drive, plus the outputs expected after it.
  function automatic void add(string tag, bit s, bit p, bit c, int t, bit d, bit r,
                              int ec, bit eb, bit ep, bit ed, bit ew);
    step_t st;
    st.tag = tag;
    st.s = s; st.p = p; st.c = c;
    st.t = WIDTH'(t); st.d = d; st.r = r;
    st.v = mk(ec, eb, ep, ed, ew);
    plan.push_back(st);
  endfunction

  task automatic apply(input step_t st);
    start  = st.s;
    stop   = st.p;
    clear  = st.c;
    term   = st.t;
    dir    = st.d;
    reload = st.r;
    sb.push_back('{tag: st.tag, v: st.v});
  endtask

  task automatic tick();
    @(posedge clk_1Hz);
    #1;
  endtask

  task automatic test_reset();
    exp_t e;
    rst = 1'b0; start = 0; stop = 0; clear = 0; term = '0; dir = 0; reload = 0;
    #1 rst = 1'b1;
    #1;
    sb.push_back('{tag: "reset_async", v: mk(0, 0, 0, 0, 0)});
    e = sb.pop_front(); checks++;
    if (observed() !== e.v) begin
      errors++; $display("FAIL %s: actual %s, expected %s", e.tag, fmt(observed()), fmt(e.v));
    end
    @(negedge clk_1Hz);
    rst = 1'b0;
    add("reset_idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add("reset_idle_stop", 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    while (plan.size() > 0) begin
      apply(plan.pop_front()); tick();
      e = sb.pop_front(); checks++;
      if (observed() !== e.v) begin
        errors++; $display("FAIL %s: actual %s, expected %s", e.tag, fmt(observed()), fmt(e.v));
      end
    end
  endtask

  task automatic test_up_oneshot();
    exp_t e;
    add("up1_start", 1, 0, 0, 5, 0, 0, 0, 1, 0, 0, 0);
    for (int i = 1; i <= 5; i++)
      add("up1_step", 0, 0, 0, 5, 0, 0, i, i < 5, 0, i == 5, 0);
    for (int i = 0; i < 2; i++)
      add("up1_hold", 0, 1, 0, 5, 0, 0, 5, 0, 0, 0, 0);
    while (plan.size() > 0) begin
      apply(plan.pop_front()); tick();
      e = sb.pop_front(); checks++;
      if (observed() !== e.v) begin
        errors++; $display("FAIL %s: actual %s, expected %s", e.tag, fmt(observed()), fmt(e.v));
      end
    end
  endtask

  task automatic test_down_reload();
    exp_t e;
    add("dr_start", 1, 0, 0, 3, 1, 1, 3, 1, 0, 0, 0);
    for (int k = 1; k <= 9; k++)
      add("dr_step", 0, 0, 0, 3, 1, 1, (k % 4 == 0) ? 3 : 3 - (k % 4), 1, 0, 0, k % 4 == 0);
    add("dr_clear", 0, 0, 1, 3, 1, 1, 0, 0, 0, 0, 0);
    while (plan.size() > 0) begin
      apply(plan.pop_front()); tick();
      e = sb.pop_front(); checks++;
      if (observed() !== e.v) begin
        errors++; $display("FAIL %s: actual %s, expected %s", e.tag, fmt(observed()), fmt(e.v));
      end
    end
  endtask

  task automatic test_pause_resume();
    exp_t e;
    add("pr_start", 1, 0, 0, 20, 0, 0, 0, 1, 0, 0, 0);
    for (int i = 1; i <= 7; i++)
      add("pr_run", 0, 0, 0, 20, 0, 0, i, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++)
      add("pr_paused", 0, 1, 0, 20, 0, 0, 7, 1, 1, 0, 0);
    add("pr_resume", 1, 0, 0, 20, 0, 0, 7, 1, 0, 0, 0);
    add("pr_step8", 0, 0, 0, 20, 0, 0, 8, 1, 0, 0, 0);
    add("pr_step9", 0, 0, 0, 20, 0, 0, 9, 1, 0, 0, 0);
    add("pr_clear", 0, 0, 1, 20, 0, 0, 0, 0, 0, 0, 0);
    while (plan.size() > 0) begin
      apply(plan.pop_front()); tick();
      e = sb.pop_front(); checks++;
      if (observed() !== e.v) begin
        errors++; $display("FAIL %s: actual %s, expected %s", e.tag, fmt(observed()), fmt(e.v));
      end
    end
  endtask

  task automatic test_priority();
    exp_t e;
    add("pri_start", 1, 0, 0, 20, 0, 0, 0, 1, 0, 0, 0);
    for (int i = 1; i <= 12; i++)
      add("pri_run", 0, 0, 0, 20, 0, 0, i, 1, 0, 0, 0);
    add("pri_all_cmds", 1, 1, 1, 20, 0, 0, 0, 0, 0, 0, 0);
    add("pri_restart", 1, 0, 0, 20, 0, 0, 0, 1, 0, 0, 0);
    add("pri_step", 0, 0, 0, 20, 0, 0, 1, 1, 0, 0, 0);
    add("pri_start_stop", 1, 1, 0, 20, 0, 0, 1, 1, 1, 0, 0);
    add("pri_pause_hold", 0, 0, 0, 20, 0, 0, 1, 1, 1, 0, 0);
    add("pri_clear", 0, 0, 1, 20, 0, 0, 0, 0, 0, 0, 0);
    while (plan.size() > 0) begin
      apply(plan.pop_front()); tick();
      e = sb.pop_front(); checks++;
      if (observed() !== e.v) begin
        errors++; $display("FAIL %s: actual %s, expected %s", e.tag, fmt(observed()), fmt(e.v));
      end
    end
  endtask

  task automatic test_latching();
    exp_t e;
    add("lat_start", 1, 0, 0, 10, 0, 0, 0, 1, 0, 0, 0);
    for (int i = 1; i <= 2; i++)
      add("lat_run", 0, 0, 0, 10, 0, 0, i, 1, 0, 0, 0);
    // Run settings change mid-run; the latched ones must keep control.
    for (int i = 3; i <= 10; i++)
      add("lat_ignored", 0, 0, 0, 4, 1, 1, i, i < 10, 0, i == 10, 0);
    add("lat_done_hold", 0, 0, 0, 4, 1, 1, 10, 0, 0, 0, 0);
    add("lat_restart", 1, 0, 0, 4, 0, 0, 0, 1, 0, 0, 0);
    for (int i = 1; i <= 4; i++)
      add("lat_new_run", 0, 0, 0, 4, 0, 0, i, i < 4, 0, i == 4, 0);
    add("lat_clear", 0, 0, 1, 4, 0, 0, 0, 0, 0, 0, 0);
    while (plan.size() > 0) begin
      apply(plan.pop_front()); tick();
      e = sb.pop_front(); checks++;
      if (observed() !== e.v) begin
        errors++; $display("FAIL %s: actual %s, expected %s", e.tag, fmt(observed()), fmt(e.v));
      end
    end
  endtask

  task automatic test_edge_cases();
    exp_t e;
    add("edge_t0_oneshot", 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    add("edge_t0_done_hold", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add("edge_t0_reload", 1, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0);
    for (int i = 0; i < 4; i++)
      add("edge_t0_wrap", 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 1);
    add("edge_t0_pause", 0, 1, 0, 0, 0, 1, 0, 1, 1, 0, 0);
    add("edge_t0_clear", 0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0);
    add("edge_down_start", 1, 0, 0, 2, 1, 0, 2, 1, 0, 0, 0);
    add("edge_down_1", 0, 0, 0, 2, 1, 0, 1, 1, 0, 0, 0);
    add("edge_down_done", 0, 0, 0, 2, 1, 0, 0, 0, 0, 1, 0);
    add("edge_down_clear", 0, 0, 1, 2, 1, 0, 0, 0, 0, 0, 0);
    while (plan.size() > 0) begin
      apply(plan.pop_front()); tick();
      e = sb.pop_front(); checks++;
      if (observed() !== e.v) begin
        errors++; $display("FAIL %s: actual %s, expected %s", e.tag, fmt(observed()), fmt(e.v));
      end
    end
  endtask

  task automatic test_async_reset();
    exp_t e;
    add("ar_start", 1, 0, 0, 20, 0, 0, 0, 1, 0, 0, 0);
    for (int i = 1; i <= 9; i++)
      add("ar_run", 0, 0, 0, 20, 0, 0, i, 1, 0, 0, 0);
    while (plan.size() > 0) begin
      apply(plan.pop_front()); tick();
      e = sb.pop_front(); checks++;
      if (observed() !== e.v) begin
        errors++; $display("FAIL %s: actual %s, expected %s", e.tag, fmt(observed()), fmt(e.v));
      end
    end
    // Assert reset between edges; outputs must clear without waiting for the clock.
    #2 rst = 1'b1;
    #1;
    sb.push_back('{tag: "ar_mid_cycle", v: mk(0, 0, 0, 0, 0)});
    e = sb.pop_front(); checks++;
    if (observed() !== e.v) begin
      errors++; $display("FAIL %s: actual %s, expected %s", e.tag, fmt(observed()), fmt(e.v));
    end
    tick();
    rst = 1'b0;
    add("ar_idle_after", 0, 0, 0, 20, 0, 0, 0, 0, 0, 0, 0);
    add("ar_restart", 1, 0, 0, 20, 0, 0, 0, 1, 0, 0, 0);
    add("ar_restart_step", 0, 0, 0, 20, 0, 0, 1, 1, 0, 0, 0);
    while (plan.size() > 0) begin
      apply(plan.pop_front()); tick();
      e = sb.pop_front(); checks++;
      if (observed() !== e.v) begin
        errors++; $display("FAIL %s: actual %s, expected %s", e.tag, fmt(observed()), fmt(e.v));
      end
    end
  endtask

  initial begin
    test_reset();
    test_up_oneshot();
    test_down_reload();
    test_pause_resume();
    test_priority();
    test_latching();
    test_edge_cases();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
